aes_req_arb: RTL and testbench

AES_REQ_ARB -- requirements
Module: aes_req_arb

---
 rtl/aes_req_arb_if.sv | 33 +++
 rtl/aes_req_arb.sv | 94 +++++++++
 tb/tb_aes_req_arb.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_req_arb_if.sv
// Requester/response/core bundle for aes_req_arb.
// The arbiter uses the slave modport; the requesters and core model use master.
interface aes_req_arb_if;
    logic         req0_valid_i;
    logic [127:0] req0_data_i;
    logic         req0_ready_o;
    logic         req1_valid_i;
    logic [127:0] req1_data_i;
    logic         req1_ready_o;
    logic         rsp0_valid_o;
    logic [127:0] rsp0_data_o;
    logic         rsp1_valid_o;
    logic [127:0] rsp1_data_o;
    logic [127:0] aes_state_o;
    logic [127:0] aes_out_i;
    logic         busy_o;
    logic [31:0]  grant_cnt0_o;
    logic [31:0]  grant_cnt1_o;

    modport slave (
        input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, aes_out_i,
        output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp0_data_o,
               rsp1_valid_o, rsp1_data_o, aes_state_o, busy_o,
               grant_cnt0_o, grant_cnt1_o
    );

    modport master (
        output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, aes_out_i,
        input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp0_data_o,
               rsp1_valid_o, rsp1_data_o, aes_state_o, busy_o,
               grant_cnt0_o, grant_cnt1_o
    );
endinterface

// File: rtl/aes_req_arb.sv
// Two-requester round-robin front end for one fixed-latency aes_128 core.
// Optional macro AES_ARB_STATS_EN enables the per-requester grant counters.
module aes_req_arb #(
    parameter int LATENCY = 21,
    parameter int MAX_OUT = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    aes_req_arb_if.slave bus
);
    localparam logic [3:0] MAX_Q = 4'(MAX_OUT);

    logic [3:0]       out0_q, out0_d, out1_q, out1_d;
    logic             ptr_q;  // last granted requester
    logic [LATENCY:0] tag_v_q, tag_id_q;
    logic [127:0]     state_q, rsp0_data_q, rsp1_data_q;
    logic             rsp0_v_q, rsp1_v_q, busy_q;
    logic             elig0, elig1, gnt0, gnt1, acc, ret0, ret1;

    always_comb begin
        elig0 = !wb_rst_i && bus.req0_valid_i && (out0_q < MAX_Q);
        elig1 = !wb_rst_i && bus.req1_valid_i && (out1_q < MAX_Q);
        gnt0  = elig0 && (!elig1 || ptr_q);
        gnt1  = elig1 && (!elig0 || !ptr_q);
        acc   = gnt0 || gnt1;
        ret0  = tag_v_q[LATENCY] && !tag_id_q[LATENCY];
        ret1  = tag_v_q[LATENCY] &&  tag_id_q[LATENCY];
        // a simultaneous accept and retire leaves the count unchanged
        out0_d = out0_q;
        if (gnt0 && !ret0) out0_d = out0_q + 4'd1;
        else if (!gnt0 && ret0) out0_d = out0_q - 4'd1;
        out1_d = out1_q;
        if (gnt1 && !ret1) out1_d = out1_q + 4'd1;
        else if (!gnt1 && ret1) out1_d = out1_q - 4'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out0_q      <= '0;
            out1_q      <= '0;
            ptr_q       <= 1'b1;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            state_q     <= '0;
            rsp0_v_q    <= 1'b0;
            rsp1_v_q    <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            if (gnt0) ptr_q <= 1'b0;
            else if (gnt1) ptr_q <= 1'b1;
            if (acc) state_q <= gnt1 ? bus.req1_data_i : bus.req0_data_i;
            tag_v_q  <= {tag_v_q[LATENCY-1:0], acc};
            tag_id_q <= {tag_id_q[LATENCY-1:0], gnt1};
            busy_q   <= |{tag_v_q[LATENCY-1:0], acc};
            rsp0_v_q <= ret0;
            rsp1_v_q <= ret1;
            if (ret0) rsp0_data_q <= bus.aes_out_i;
            if (ret1) rsp1_data_q <= bus.aes_out_i;
        end
    end

`ifdef AES_ARB_STATS_EN
    logic [31:0] gcnt0_q, gcnt1_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (gnt0) gcnt0_q <= gcnt0_q + 32'd1;
            if (gnt1) gcnt1_q <= gcnt1_q + 32'd1;
        end
    end

    assign bus.grant_cnt0_o = gcnt0_q;
    assign bus.grant_cnt1_o = gcnt1_q;
`else
    assign bus.grant_cnt0_o = '0;
    assign bus.grant_cnt1_o = '0;
`endif

    assign bus.req0_ready_o = gnt0;
    assign bus.req1_ready_o = gnt1;
    assign bus.rsp0_valid_o = rsp0_v_q;
    assign bus.rsp0_data_o  = rsp0_data_q;
    assign bus.rsp1_valid_o = rsp1_v_q;
    assign bus.rsp1_data_o  = rsp1_data_q;
    assign bus.aes_state_o  = state_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_aes_req_arb.sv
// Randomised bench for aes_req_arb: a queue-based model of in-flight requests
// plus a delay-line core model that answers LATENCY cycles after the state changes.
module tb_aes_req_arb;
    localparam int L = 21;
    localparam int M = 4;

    typedef struct {
        logic         id;
        logic [127:0] d;
        int           due;
    } ent_t;

    logic clk, rst;
    int   cyc, n_chk, n_fail;
    aes_req_arb_if bus();

    aes_req_arb #(.LATENCY(L), .MAX_OUT(M)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

    ent_t         q[$];
    logic         exp_rdy0, exp_rdy1, exp_rsp0_v, exp_rsp1_v, exp_busy, ptr_m;
    logic [127:0] exp_rsp0_d, exp_rsp1_d, exp_state, last0, last1;
    logic [31:0]  g0, g1;
    logic [127:0] hist [64];

    function automatic logic [127:0] core_f(input logic [127:0] x);
        return ({x[62:0], x[127:63]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0) + 128'd1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // core model: cycle counter plus a delay line on aes_state_o
    initial begin
        cyc = 0;
        bus.aes_out_i = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            hist[cyc % 64] = bus.aes_state_o;
            bus.aes_out_i = (cyc >= L) ? core_f(hist[(cyc - L) % 64]) : '0;
        end
    end

    // apply this cycle's inputs and derive the expected outputs for this cycle
    task automatic drive(input logic v0, input logic [127:0] d0, input logic v1,
                         input logic [127:0] d1, input logic r);
        int   n0, n1;
        logic e0, e1;
        rst = r;
        bus.req0_valid_i = v0; bus.req0_data_i = d0;
        bus.req1_valid_i = v1; bus.req1_data_i = d1;
        exp_rsp0_v = 1'b0; exp_rsp1_v = 1'b0;
        while (q.size() > 0 && q[0].due <= cyc) begin
            if (q[0].due == cyc) begin
                if (q[0].id) begin exp_rsp1_v = 1'b1; last1 = core_f(q[0].d); end
                else begin exp_rsp0_v = 1'b1; last0 = core_f(q[0].d); end
            end
            void'(q.pop_front());
        end
        exp_rsp0_d = last0; exp_rsp1_d = last1;
        exp_busy = (q.size() > 0);
        n0 = 0; n1 = 0;
        foreach (q[i]) if (q[i].id) n1++; else n0++;
        e0 = !r && v0 && (n0 < M);
        e1 = !r && v1 && (n1 < M);
        exp_rdy0 = e0 && (!e1 || ptr_m);
        exp_rdy1 = e1 && (!e0 || !ptr_m);
        #1;
    endtask

    // commit the model for the closing edge, then move to the next cycle
    task automatic advance();
        if (rst) begin
            q.delete(); ptr_m = 1'b1; last0 = '0; last1 = '0;
            exp_state = '0; g0 = '0; g1 = '0;
        end else if (exp_rdy0) begin
            q.push_back('{id: 1'b0, d: bus.req0_data_i, due: cyc + L + 2});
            exp_state = bus.req0_data_i; ptr_m = 1'b0; g0 = g0 + 32'd1;
        end else if (exp_rdy1) begin
            q.push_back('{id: 1'b1, d: bus.req1_data_i, due: cyc + L + 2});
            exp_state = bus.req1_data_i; ptr_m = 1'b1; g1 = g1 + 32'd1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, rnd128(), 1'b1, rnd128(), 1'b1);
        n_chk++;
        if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got %b%b expected 00", bus.req0_ready_o, bus.req1_ready_o);
        end
        advance();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        n_chk++;
        if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.busy_o} !== 3'b000 ||
            bus.rsp0_data_o !== '0 || bus.rsp1_data_o !== '0 || bus.aes_state_o !== '0 ||
            bus.grant_cnt0_o !== '0 || bus.grant_cnt1_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b%b busy=%b state=%h expected all 0",
                     bus.rsp0_valid_o, bus.rsp1_valid_o, bus.busy_o, bus.aes_state_o);
        end
        advance();
    endtask

    task automatic test_single_req();
        logic [127:0] pt;
        int rsp_cyc;
        pt = 128'h00112233445566778899AABBCCDDEEFF;
        rsp_cyc = -1;
        while (cyc < 5) begin drive(1'b0, '0, 1'b0, '0, 1'b0); advance(); end
        drive(1'b1, pt, 1'b0, '0, 1'b0);
        n_chk++;
        if (bus.req0_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL single_ready got %b expected 1", bus.req0_ready_o);
        end
        advance();
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0);
            n_chk++;
            if (bus.rsp0_valid_o !== exp_rsp0_v || bus.rsp1_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL single_rsp_valid cyc=%0d got %b%b expected %b0", cyc,
                         bus.rsp0_valid_o, bus.rsp1_valid_o, exp_rsp0_v);
            end
            if (bus.rsp0_valid_o === 1'b1) begin
                rsp_cyc = cyc;
                n_chk++;
                if (bus.rsp0_data_o !== core_f(pt)) begin
                    n_fail++;
                    $display("FAIL single_rsp_data got %h expected %h", bus.rsp0_data_o, core_f(pt));
                end
            end
            advance();
        end
        n_chk++;
        if (rsp_cyc != 28) begin
            n_fail++; $display("FAIL single_latency got cycle %0d expected 28", rsp_cyc);
        end
    endtask

    task automatic test_alternate();
        int gseq[$];
        int early;
        early = 0;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            drive(1'b1, rnd128(), 1'b1, rnd128(), 1'b0);
            n_chk++;
            if (bus.req0_ready_o !== exp_rdy0 || bus.req1_ready_o !== exp_rdy1) begin
                n_fail++;
                $display("FAIL alt_ready r=%0d got %b%b expected %b%b", r,
                         bus.req0_ready_o, bus.req1_ready_o, exp_rdy0, exp_rdy1);
            end
            n_chk++;
            if (bus.rsp0_valid_o !== exp_rsp0_v || bus.rsp1_valid_o !== exp_rsp1_v ||
                bus.rsp0_data_o !== exp_rsp0_d || bus.rsp1_data_o !== exp_rsp1_d) begin
                n_fail++;
                $display("FAIL alt_rsp r=%0d got %b%b expected %b%b", r,
                         bus.rsp0_valid_o, bus.rsp1_valid_o, exp_rsp0_v, exp_rsp1_v);
            end
            if (bus.req0_ready_o === 1'b1) gseq.push_back(0);
            if (bus.req1_ready_o === 1'b1) gseq.push_back(1);
            if (r == 22) early = gseq.size();
            advance();
        end
        n_chk++;
        if (early != 8) begin
            n_fail++; $display("FAIL alt_stop got %0d grants expected 8", early);
        end
        for (int i = 0; i < 8 && i < gseq.size(); i++) begin
            n_chk++;
            if (gseq[i] != i % 2) begin
                n_fail++; $display("FAIL alt_order idx=%0d got %0d expected %0d", i, gseq[i], i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc_n, fifth, first_rsp;
        acc_n = 0; fifth = -1; first_rsp = -1;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            drive(1'b1, rnd128(), 1'b0, '0, 1'b0);
            n_chk++;
            if (bus.req0_ready_o !== exp_rdy0) begin
                n_fail++;
                $display("FAIL bp_ready r=%0d got %b expected %b", r, bus.req0_ready_o, exp_rdy0);
            end
            if (bus.rsp0_valid_o === 1'b1 && first_rsp < 0) first_rsp = r;
            if (bus.req0_ready_o === 1'b1) begin
                acc_n++;
                if (acc_n == 5) fifth = r;
            end
            advance();
        end
        n_chk++;
        if (first_rsp != 23 || fifth != 23) begin
            n_fail++;
            $display("FAIL bp_resume got rsp=%0d accept5=%0d expected 23/23", first_rsp, fifth);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(r != 1, rnd128(), r == 1, rnd128(), 1'b0);
            advance();
        end
        for (int r = 0; r < 10; r++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0);
            n_chk++;
            if (bus.busy_o !== 1'b1) begin
                n_fail++; $display("FAIL mid_busy r=%0d got %b expected 1", r, bus.busy_o);
            end
            advance();
        end
        do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        n_chk++;
        if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.busy_o} !== 3'b000 ||
            bus.rsp0_data_o !== '0 || bus.rsp1_data_o !== '0 || bus.aes_state_o !== '0) begin
            n_fail++;
            $display("FAIL mid_clear got v=%b%b busy=%b expected 000",
                     bus.rsp0_valid_o, bus.rsp1_valid_o, bus.busy_o);
        end
        advance();
        for (int r = 0; r < 40; r++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0);
            n_chk++;
            if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_ghost r=%0d got v=%b%b busy=%b expected 000", r,
                         bus.rsp0_valid_o, bus.rsp1_valid_o, bus.busy_o);
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 400; r++) begin
            drive($urandom_range(0, 9) < 6, rnd128(), $urandom_range(0, 9) < 6, rnd128(), 1'b0);
            n_chk++;
            if (bus.req0_ready_o !== exp_rdy0 || bus.req1_ready_o !== exp_rdy1) begin
                n_fail++;
                $display("FAIL rnd_ready r=%0d got %b%b expected %b%b", r,
                         bus.req0_ready_o, bus.req1_ready_o, exp_rdy0, exp_rdy1);
            end
            n_chk++;
            if (bus.rsp0_valid_o !== exp_rsp0_v || bus.rsp1_valid_o !== exp_rsp1_v ||
                bus.rsp0_data_o !== exp_rsp0_d || bus.rsp1_data_o !== exp_rsp1_d) begin
                n_fail++;
                $display("FAIL rnd_rsp r=%0d got %b%b %h expected %b%b %h", r,
                         bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp0_data_o,
                         exp_rsp0_v, exp_rsp1_v, exp_rsp0_d);
            end
            n_chk++;
            if (bus.busy_o !== exp_busy || bus.aes_state_o !== exp_state) begin
                n_fail++;
                $display("FAIL rnd_state r=%0d got busy=%b %h expected busy=%b %h", r,
                         bus.busy_o, bus.aes_state_o, exp_busy, exp_state);
            end
            advance();
        end
    endtask

    task automatic test_stats();
        int a0, a1;
        logic [31:0] e0, e1;
        a0 = 0; a1 = 0;
        do_reset();
        for (int r = 0; r < 300 && (a0 < 5 || a1 < 3); r++) begin
            drive(a0 < 5 && $urandom_range(0, 1) == 1, rnd128(),
                  a1 < 3 && $urandom_range(0, 1) == 1, rnd128(), 1'b0);
            if (bus.req0_ready_o === 1'b1) a0++;
            if (bus.req1_ready_o === 1'b1) a1++;
            advance();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0);
`ifdef AES_ARB_STATS_EN
        e0 = 32'd5; e1 = 32'd3;
`else
        e0 = 32'd0; e1 = 32'd0;
`endif
        n_chk++;
        if (bus.grant_cnt0_o !== e0 || bus.grant_cnt1_o !== e1) begin
            n_fail++;
            $display("FAIL stats got %0d/%0d expected %0d/%0d (accepted %0d/%0d)",
                     bus.grant_cnt0_o, bus.grant_cnt1_o, e0, e1, a0, a1);
        end
        advance();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; ptr_m = 1'b1; q.delete();
        last0 = '0; last1 = '0; exp_state = '0; g0 = '0; g1 = '0;
        bus.req0_valid_i = 1'b0; bus.req0_data_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_data_i = '0;
        test_reset();
        test_single_req();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
